// File: rtl/apb_uart_tx_fifo.sv
// apb_uart_tx_fifo: APB-programmable UART transmitter with TX FIFO, baud divisor and done interrupt
module apb_uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4,
    parameter int DIV_RESET  = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic              irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW:0]       wptr, rptr, count;
    logic [DATA_W-1:0] div_reg, div_lat, cnt, shift, rdata;
    logic [BW-1:0]     bit_idx;
    logic              tx_en, irq_en, ovf;
    logic              access, wr, rd, sel_tx, sel_st, sel_div, sel_ctrl, bad_addr;
    logic              full, empty, push_ok, push_ovf, pop, tick, last_bit;

    assign access   = PSELx & PENABLE;
    assign wr       = access & PWRITE;
    assign rd       = access & !PWRITE;
    assign sel_tx   = PADDR == ADDR_W'(0);
    assign sel_st   = PADDR == ADDR_W'(1);
    assign sel_div  = PADDR == ADDR_W'(2);
    assign sel_ctrl = PADDR == ADDR_W'(3);
    assign bad_addr = !(sel_tx | sel_st | sel_div | sel_ctrl);

    assign count    = wptr - rptr;
    assign full     = count == (PW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign push_ok  = wr & sel_tx & !full;
    assign push_ovf = wr & sel_tx & full;
    assign pop      = (state == IDLE) & tx_en & !empty;
    assign tick     = cnt == div_lat - DATA_W'(1);
    assign last_bit = bit_idx == BW'(DATA_W - 1);

    assign rdata   = sel_st   ? DATA_W'({ovf, tx_busy, full, empty}) :
                     sel_div  ? div_reg :
                     sel_ctrl ? DATA_W'({irq_en, tx_en}) : '0;
    assign PRDATA  = rd ? rdata : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = (access & bad_addr) | push_ovf;

    assign uart_txd = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    assign tx_busy  = state != IDLE;
    assign irq      = irq_en & empty & !tx_busy & (state == IDLE);

    // Control registers and sticky overflow flag (cleared by a STATUS read)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_reg <= DATA_W'(DIV_RESET);
            tx_en   <= 1'b1;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr && sel_div) div_reg <= PWDATA;
            if (wr && sel_ctrl) begin
                tx_en  <= PWDATA[0];
                irq_en <= PWDATA[1];
            end
            if (push_ovf) ovf <= 1'b1;
            else if (rd && sel_st) ovf <= 1'b0;
        end
    end

    // FIFO pointers; one extra bit separates full from empty
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + (PW+1)'(1);
            if (pop) rptr <= rptr + (PW+1)'(1);
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge PCLK) begin
        if (push_ok) mem[wptr[PW-1:0]] <= PWDATA;
    end

    // TX state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else state <= state_next;
    end

    // TX next-state: each non-idle state lasts div_lat cycles, DATA repeats per bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pop ? START : IDLE;
            START:   state_next = tick ? DATA : START;
            DATA:    state_next = tick && last_bit ? STOP : DATA;
            STOP:    state_next = tick ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    // Shift register, bit timer and divisor latched at pop so DIV writes never touch a live frame
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            shift   <= '0;
            div_lat <= DATA_W'(1);
            cnt     <= '0;
            bit_idx <= '0;
        end else if (pop) begin
            shift   <= mem[rptr[PW-1:0]];
            div_lat <= div_reg == '0 ? DATA_W'(1) : div_reg;
            cnt     <= '0;
            bit_idx <= '0;
        end else if (state != IDLE) begin
            cnt <= tick ? '0 : cnt + DATA_W'(1);
            if (tick && state == DATA) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_apb_uart_tx_fifo.sv
// tb_apb_uart_tx_fifo: scoreboard bench for the APB UART transmitter
module tb_apb_uart_tx_fifo;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [3:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR, uart_txd, tx_busy, irq;

    int passed = 0;
    int total = 0;
    int frames_rx = 0;
    int model_div = 16;
    logic [7:0] sb[$];

    apb_uart_tx_fifo dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .uart_txd(uart_txd),
        .tx_busy(tx_busy), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    // Frame monitor: decodes each frame at mid-bit and compares against the scoreboard head
    initial begin : monitor
        logic       prev;
        logic [7:0] exp_d, got;
        int         d;
        bit         ab, have, start_ok, stop_ok;
        prev = 1'b1;
        forever begin
            @(posedge PCLK); #1;
            if (PRESETn && prev && !uart_txd) begin
                have = sb.size() > 0;
                exp_d = have ? sb.pop_front() : 8'h00;
                d = model_div;
                got = '0; ab = 0; start_ok = 0; stop_ok = 0;
                for (int c = 0; c < d * 10; c++) begin
                    if (c > 0) begin @(posedge PCLK); #1; end
                    if (!PRESETn) begin ab = 1; break; end
                    if (c == d / 2) start_ok = !uart_txd;
                    if (c >= d && c < d * 9 && (c % d) == d / 2) got[c / d - 1] = uart_txd;
                    if (c == d * 9 + d / 2) stop_ok = uart_txd;
                end
                if (!ab) begin
                    total++; frames_rx++;
                    if (!have || got !== exp_d || !start_ok || !stop_ok)
                        $display("FAIL frame %0d: got data %h start %0b stop %0b, required data %h start 1 stop 1 (expected present %0b)",
                                 frames_rx, got, start_ok, stop_ok, exp_d, have);
                    else passed++;
                end
            end
            prev = uart_txd;
        end
    end

    task automatic apb(input logic w, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] rdat, output logic err);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdat = PRDATA; err = PSLVERR;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        for (int c = 0; c < limit && frames_rx < target; c++) @(posedge PCLK);
        #1;
        total++;
        if (frames_rx !== target) $display("FAIL wait_frames: got %0d frames, required %0d", frames_rx, target);
        else passed++;
    endtask

    task automatic test_reset;
        logic [7:0] r; logic e;
        #1;
        total++;
        if ({uart_txd, tx_busy, irq, PSLVERR, PREADY} !== 5'b10001 || PRDATA !== 8'h00)
            $display("FAIL reset_outputs: got txd/busy/irq/err/ready %b%b%b%b%b prdata %h, required 10001 prdata 00",
                     uart_txd, tx_busy, irq, PSLVERR, PREADY, PRDATA);
        else passed++;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK); PRESETn = 1'b1;
        apb(0, 4'h1, 0, r, e);
        total++;
        if (r !== 8'h01 || e !== 1'b0) $display("FAIL reset_status: got %h err %b, required 01 err 0", r, e);
        else passed++;
        apb(0, 4'h2, 0, r, e);
        total++;
        if (r !== 8'd16) $display("FAIL reset_div: got %0d, required 16", r);
        else passed++;
        apb(0, 4'h3, 0, r, e);
        total++;
        if (r !== 8'h01 || irq !== 1'b0) $display("FAIL reset_ctrl: got %h irq %b, required 01 irq 0", r, irq);
        else passed++;
    endtask

    task automatic test_single_frame;
        logic [7:0] r; logic e; int n;
        apb(1, 4'h2, 8'd4, r, e);
        model_div = 4;
        apb(1, 4'h0, 8'hA5, r, e);
        sb.push_back(8'hA5);
        total++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || e !== 1'b0)
            $display("FAIL latency_n: got txd %b busy %b err %b, required 1 0 0", uart_txd, tx_busy, e);
        else passed++;
        @(posedge PCLK); #1;
        total++;
        if (uart_txd !== 1'b0 || tx_busy !== 1'b1)
            $display("FAIL latency_n1: got txd %b busy %b, required 0 1", uart_txd, tx_busy);
        else passed++;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!tx_busy) break;
            n++;
            @(posedge PCLK); #1;
        end
        total++;
        if (n !== 40) $display("FAIL busy_len: got %0d cycles, required 40", n);
        else passed++;
        wait_frames(1, 50);
    endtask

    task automatic test_overflow;
        logic [7:0] r; logic e; int bad;
        apb(1, 4'h3, 8'h00, r, e);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            apb(1, 4'h0, 8'h10 + 8'(i * 7), r, e);
            if (i < 8) sb.push_back(8'h10 + 8'(i * 7));
            if (i < 8 && e !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL ovf_accept: got %0d error responses on first 8 pushes, required 0", bad);
        else passed++;
        total++;
        if (e !== 1'b1) $display("FAIL ovf_pslverr: got %b on 9th push, required 1", e);
        else passed++;
        apb(0, 4'h1, 0, r, e);
        total++;
        if (r !== 8'h0A) $display("FAIL ovf_status1: got %h, required 0A", r);
        else passed++;
        apb(0, 4'h1, 0, r, e);
        total++;
        if (r !== 8'h02) $display("FAIL ovf_status2: got %h, required 02", r);
        else passed++;
        apb(1, 4'h3, 8'h01, r, e);
        wait_frames(9, 1000);
    endtask

    task automatic test_irq;
        logic [7:0] r; logic e; int bad; bit done;
        apb(1, 4'h3, 8'h03, r, e);
        total++;
        if (irq !== 1'b1) $display("FAIL irq_idle: got %b, required 1", irq);
        else passed++;
        apb(1, 4'h0, 8'h3C, r, e);
        sb.push_back(8'h3C);
        bad = (irq !== 1'b0) ? 1 : 0;
        done = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge PCLK); #1;
            if (!tx_busy) begin done = 1; break; end
            if (irq !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0 || !done) $display("FAIL irq_during: got %0d cycles with irq high (done %0b), required 0 (done 1)", bad, done);
        else passed++;
        total++;
        if (irq !== 1'b1) $display("FAIL irq_after: got %b, required 1", irq);
        else passed++;
        apb(1, 4'h3, 8'h01, r, e);
        wait_frames(10, 50);
    endtask

    task automatic test_back_to_back;
        logic [7:0] r; logic e; int n;
        apb(1, 4'h0, 8'h5A, r, e);
        sb.push_back(8'h5A);
        apb(1, 4'h0, 8'hC3, r, e);
        sb.push_back(8'hC3);
        repeat (6) @(posedge PCLK);
        apb(1, 4'h2, 8'd8, r, e);
        model_div = 8;
        n = 0;
        for (int c = 0; c < 100 && tx_busy; c++) begin
            n++;
            @(posedge PCLK); #1;
        end
        total++;
        if (n < 20 || n > 35) $display("FAIL div_hold: got %0d remaining busy cycles, required 20..35 at DIV 4", n);
        else passed++;
        @(posedge PCLK); #1;
        total++;
        if (tx_busy !== 1'b1) $display("FAIL b2b_gap: got busy %b after one idle cycle, required 1", tx_busy);
        else passed++;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!tx_busy) break;
            n++;
            @(posedge PCLK); #1;
        end
        total++;
        if (n !== 80) $display("FAIL div_next: got %0d busy cycles, required 80", n);
        else passed++;
        wait_frames(12, 50);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] r; logic e;
        apb(1, 4'h0, 8'h00, r, e);
        sb.push_back(8'h00);
        apb(1, 4'h0, 8'h11, r, e);
        sb.push_back(8'h11);
        repeat (40) @(posedge PCLK);
        @(negedge PCLK); #2;
        total++;
        if (uart_txd !== 1'b0 || tx_busy !== 1'b1) $display("FAIL mid_data: got txd %b busy %b, required 0 1", uart_txd, tx_busy);
        else passed++;
        PRESETn = 1'b0;
        #1;
        total++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) $display("FAIL async_reset: got txd %b busy %b, required 1 0", uart_txd, tx_busy);
        else passed++;
        sb.delete();
        model_div = 16;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK); PRESETn = 1'b1;
        apb(0, 4'h1, 0, r, e);
        total++;
        if (r !== 8'h01) $display("FAIL rst_status: got %h, required 01", r);
        else passed++;
        apb(0, 4'h2, 0, r, e);
        total++;
        if (r !== 8'd16) $display("FAIL rst_div: got %0d, required 16", r);
        else passed++;
    endtask

    task automatic test_bad_addr;
        logic [7:0] r; logic e;
        apb(0, 4'h7, 0, r, e);
        total++;
        if (e !== 1'b1 || r !== 8'h00) $display("FAIL bad_read: got err %b prdata %h, required 1 00", e, r);
        else passed++;
        apb(1, 4'h7, 8'h55, r, e);
        total++;
        if (e !== 1'b1) $display("FAIL bad_write: got err %b, required 1", e);
        else passed++;
        apb(1, 4'h1, 8'hFF, r, e);
        total++;
        if (e !== 1'b0) $display("FAIL status_write: got err %b, required 0", e);
        else passed++;
        apb(0, 4'h0, 0, r, e);
        total++;
        if (r !== 8'h00 || e !== 1'b0) $display("FAIL txdata_read: got %h err %b, required 00 0", r, e);
        else passed++;
    endtask

    task automatic test_post_reset_frame;
        logic [7:0] r; logic e;
        apb(1, 4'h0, 8'h96, r, e);
        sb.push_back(8'h96);
        wait_frames(13, 400);
        total++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_overflow;
        test_irq;
        test_back_to_back;
        test_reset_mid_frame;
        test_bad_addr;
        test_post_reset_frame;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
